key_debounce_filter: RTL and testbench
======================================

// Module: key_debounce_filter
// PURPOSE
//  Debounces one raw active-low push-button (e.g. DE0-CV KEY) into a glitch-free level.
//  key_level feeds the in_port of the CPU-side edge-capture PIO.
//  Also emits one-cycle press/release strobes for hardware consumers.
//  One instance per key; sits between the FPGA pin and the PIO slave.
// PARAMETERS
//  SYNC_STAGES      2          metastability flops on key_n_in (legal range 2..4)
//  DEBOUNCE_CYCLES  1000000    clk cycles the new level must hold before acceptance (20 ms @ 50 MHz); >=2
//  LONG_CYCLES      100000000  clk cycles held pressed before long_press (2 s @ 50 MHz); LONG_PRESS_EN only
// PORTS
//  clk            in   1  system clock
//  reset_n        in   1  asynchronous, active-low reset
//  key_n_in       in   1  raw button pin, 0 = pressed, asynchronous to clk
//  key_level      out  1  debounced level, 0 = pressed; connects to PIO in_port
//  press_pulse    out  1  one-cycle strobe when an accepted press occurs
//  release_pulse  out  1  one-cycle strobe when an accepted release occurs
//  long_press     out  1  high while held beyond LONG_CYCLES (LONG_PRESS_EN only)
// BEHAVIOUR
//  Reset: sync flops=1, state=RELEASED, cnt=0, key_level=1, pulses=0, long_press=0.
//  Sync: SYNC_STAGES-flop chain; key_s = last stage. No logic before the chain.
//  FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
//   RELEASED:    key_s==0 -> PRESS_CHK, cnt<=0.
//   PRESS_CHK:   key_s==1 -> RELEASED, cnt<=0 (bounce rejected, no output change);
//                else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, key_level<=0, press_pulse<=1;
//                else cnt++.
//   PRESSED:     key_s==1 -> RELEASE_CHK, cnt<=0.
//   RELEASE_CHK: key_s==0 -> PRESSED, cnt<=0;
//                else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED, key_level<=1, release_pulse<=1;
//                else cnt++.
//  Outputs are registered. press_pulse and release_pulse are high for exactly 1 cycle and never together.
//  Latency: clean edge on key_n_in -> key_level change after SYNC_STAGES+DEBOUNCE_CYCLES+1 clk (+-1 for sync sampling).
//  Any bounce shorter than DEBOUNCE_CYCLES during a CHK state restarts qualification from zero.
//  cnt width = $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1). Never wraps: held at terminal value.
//  Reset asserted mid-CHK: returns immediately to reset values with no pulse. The first post-reset press needs full qualification.
//  Key held pressed through reset release: the press is reported after qualification (one press_pulse).
// CONFIGURATION
//  LONG_PRESS_EN defined:
//   - Separate hold counter runs in PRESSED and RELEASE_CHK.
//   - Hold counter clears on entry to RELEASED.
//   - Hold counter saturates at LONG_CYCLES.
//   - long_press<=1 when the hold counter reaches LONG_CYCLES-1 (measured from press acceptance).
//   - long_press stays 1 until release is accepted, then clears in the same cycle as release_pulse.
//   - long_press stays 1 through RELEASE_CHK bounce.
//  LONG_PRESS_EN undefined:
//   - No hold counter is synthesised.
//   - long_press is tied to 0 and the port remains present.
// STRUCTURE
//  Package key_debounce_pkg:
//   - key_state_t enum {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}
//   - KEY_PRESSED=1'b0, KEY_RELEASED=1'b1 constants
//   - cnt_width(max) function
//  Sub-module key_sync: parameterised SYNC_STAGES flop chain, reset value 1, async active-low reset.
//  Top level holds the FSM, counters and output registers.
// TESTING (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, LONG_PRESS_EN defined)
//  1. Reset with key_n_in=1 -> key_level=1, press/release/long=0, held for 50 cycles.
//  2. key_n_in 1->0 clean -> key_level 0 at cycle 2+8+1 (+-1), press_pulse exactly 1 cycle.
//  3. Bounce: 0 for 5 clk, 1 for 3 clk, repeated 4x, then 1 -> key_level stays 1, no pulses.
//  4. Press accepted, then release with 3-clk glitches, then stable 1 -> single release_pulse, key_level=1.
//  5. Hold 0 for 40 clk after acceptance -> long_press rises 32 clk after press_pulse, falls with release_pulse.
//  6. Assert reset_n=0 in PRESS_CHK at cnt=5 -> outputs return to reset values, no press_pulse.
//     After reset release, press is reported after full requalification.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button debounce filter.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_filter_sync.sv
// Metastability chain for the raw key pin; idles at the released level (1).
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_debounce_filter.sv
// Debounces one active-low push-button into a clean level plus press/release strobes.
// Define LONG_PRESS_EN to build the hold counter that drives long_press.
module key_debounce_filter
  import key_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W = cnt_width((LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       key_s;
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       key_level_q, key_level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       press_acc, release_acc;

  key_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_n_in),
    .q       (key_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      key_level_q <= KEY_RELEASED;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  // Any disagreement during a check state restarts qualification from zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_acc   = 1'b0;
    release_acc = 1'b0;
    case (state_q)
      RELEASED: begin
        if (key_s == KEY_PRESSED) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s == KEY_RELEASED) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          press_acc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s == KEY_RELEASED) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (key_s == KEY_PRESSED) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = RELEASED;
          release_acc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    key_level_d = key_level_q;
    if (press_acc) begin
      key_level_d = KEY_PRESSED;
    end
    if (release_acc) begin
      key_level_d = KEY_RELEASED;
    end
    press_d   = press_acc;
    release_d = release_acc;
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold time keeps accumulating through release bounces; only an accepted release clears it.
  always_comb begin
    hold_d = hold_q;
    long_d = long_q;
    if (state_q == PRESSED || state_q == RELEASE_CHK) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + CNT_ONE;
      end
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
      end
    end
    if (release_acc) begin
      hold_d = '0;
      long_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_filter.sv
// Directed bench for key_debounce_filter with SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
module tb_key_debounce_filter;

`ifdef LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic key_n_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int errors = 0;
  int checks = 0;
  int press_cnt = 0;
  int rel_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic press_prev = 1'b0;
  logic rel_prev = 1'b0;

  key_debounce_filter #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_n_in      (key_n_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  // Strobe bookkeeping, sampled just after each active edge.
  always @(posedge clk) begin
    #2;
    if (press_pulse && release_pulse) both_cnt++;
    if (press_pulse && press_prev) wide_cnt++;
    if (release_pulse && rel_prev) wide_cnt++;
    press_cnt += int'(press_pulse);
    rel_cnt   += int'(release_pulse);
    press_prev = press_pulse;
    rel_prev   = release_pulse;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    key_n_in = 1'b1;

    // 1: reset held for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0 || i == 49) begin
        check("rst_level", 32'(key_level), 32'd1);
        check("rst_press", 32'(press_pulse), 32'd0);
        check("rst_release", 32'(release_pulse), 32'd0);
        check("rst_long", 32'(long_press), 32'd0);
      end
    end
    reset_n = 1'b1;
    step(5);
    check("idle_level", 32'(key_level), 32'd1);

    // 2: clean press, accepted on edge 11
    key_n_in = 1'b0;
    step(10);
    check("press_early", 32'(key_level), 32'd1);
    step(1);
    check("press_level", 32'(key_level), 32'd0);
    check("press_pulse", 32'(press_pulse), 32'd1);
    step(1);
    check("press_pulse_end", 32'(press_pulse), 32'd0);
    check("press_count1", 32'(press_cnt), 32'd1);

    // 5: long press rises 32 edges after acceptance, falls with release_pulse
    step(30);
    check("long_early", 32'(long_press), 32'd0);
    step(1);
    check("long_rise", 32'(long_press), 32'(LP));
    step(8);
    key_n_in = 1'b1;
    step(10);
    check("rel_early", 32'(key_level), 32'd0);
    check("long_held", 32'(long_press), 32'(LP));
    step(1);
    check("rel_level", 32'(key_level), 32'd1);
    check("rel_pulse", 32'(release_pulse), 32'd1);
    check("long_fall", 32'(long_press), 32'd0);
    check("rel_count1", 32'(rel_cnt), 32'd1);
    step(5);

    // 3: press bounce never qualifies
    for (int i = 0; i < 4; i++) begin
      key_n_in = 1'b0;
      step(5);
      key_n_in = 1'b1;
      step(3);
    end
    step(20);
    check("bounce_level", 32'(key_level), 32'd1);
    check("bounce_press", 32'(press_cnt), 32'd1);
    check("bounce_rel", 32'(rel_cnt), 32'd1);

    // 4: press, then release with 3-clk glitches back to pressed
    key_n_in = 1'b0;
    step(11);
    check("p4_level", 32'(key_level), 32'd0);
    check("p4_press", 32'(press_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      key_n_in = 1'b1;
      step(5);
      key_n_in = 1'b0;
      step(3);
    end
    key_n_in = 1'b1;
    step(10);
    check("glitch_level", 32'(key_level), 32'd0);
    check("glitch_rel", 32'(rel_cnt), 32'd1);
    step(1);
    check("r4_level", 32'(key_level), 32'd1);
    check("r4_pulse", 32'(release_pulse), 32'd1);
    check("r4_count", 32'(rel_cnt), 32'd2);
    step(1);
    check("r4_long", 32'(long_press), 32'd0);
    step(5);

    // 6: reset while PRESS_CHK has cnt=5, then full requalification
    key_n_in = 1'b0;
    step(8);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(key_level), 32'd1);
    check("mid_rst_press", 32'(press_pulse), 32'd0);
    check("mid_rst_long", 32'(long_press), 32'd0);
    step(3);
    check("mid_rst_count", 32'(press_cnt), 32'd2);
    reset_n = 1'b1;
    step(10);
    check("requal_early", 32'(key_level), 32'd1);
    step(1);
    check("requal_level", 32'(key_level), 32'd0);
    check("requal_pulse", 32'(press_pulse), 32'd1);
    check("requal_count", 32'(press_cnt), 32'd3);
    step(2);

    check("pulse_overlap", 32'(both_cnt), 32'd0);
    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
